// File: rtl/mips_mem_arbiter.sv
// Unified I/D memory arbiter: serialises IF fetches and DM loads/stores onto one memory port.
// Optional IF anti-starvation is enabled by defining ARB_FAIR_EN.
module mips_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state;
  logic [2:0] lat_cnt;
  logic       win_dm;
  logic       any_req;
  logic       if_wins;

  if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_LIM < 1) begin : g_bad_param
    $error("mips_mem_arbiter: MEM_LAT must be 1..7 and STARVE_LIM >= 1");
  end

  assign any_req = if_req | dm_req;

`ifdef ARB_FAIR_EN
  localparam int SW = $clog2(STARVE_LIM + 2);
  logic [SW-1:0] starve_cnt;

  // IF takes a conflict once DM has beaten a waiting IF STARVE_LIM times in a row.
  assign if_wins = if_req && (!dm_req || starve_cnt == SW'(STARVE_LIM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE && any_req) begin
      if (if_wins)
        starve_cnt <= '0;
      else if (if_req)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign if_wins = if_req && !dm_req;
`endif

  // Single FSM: every port output is a register loaded on the transition that needs it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      win_dm    <= 1'b0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_gnt    <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if_rvalid <= 1'b0;
          dm_rvalid <= 1'b0;
          if (any_req) begin
            state     <= ACCESS;
            lat_cnt   <= 3'(MEM_LAT - 1);
            win_dm    <= !if_wins;
            if_gnt    <= if_wins;
            dm_gnt    <= !if_wins;
            mem_en    <= 1'b1;
            mem_we    <= if_wins ? 1'b0 : dm_we;
            mem_addr  <= if_wins ? if_addr : dm_addr;
            mem_wdata <= if_wins ? '0 : dm_wdata;
            busy      <= 1'b1;
          end
        end
        ACCESS: begin
          if_gnt <= 1'b0;
          dm_gnt <= 1'b0;
          if (lat_cnt == 3'd0) begin
            state  <= RESP;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (win_dm) begin
              dm_rvalid <= 1'b1;
              if (!mem_we)
                dm_rdata <= mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          if_rvalid <= 1'b0;
          dm_rvalid <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: a MEM_LAT=1 instance with a RAM model
// and a MEM_LAT=3 instance with a fixed address-pattern memory.
module tb_mips_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A (MEM_LAT=1)
  logic        a_if_req = 1'b0, a_dm_req = 1'b0, a_dm_we = 1'b0;
  logic [9:0]  a_if_addr = '0, a_dm_addr = '0;
  logic [31:0] a_dm_wdata = '0;
  logic        a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_if_rdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;
  logic [9:0]  a_mem_addr;

  // Instance B (MEM_LAT=3)
  logic        b_if_req = 1'b0, b_dm_req = 1'b0, b_dm_we = 1'b0;
  logic [9:0]  b_if_addr = '0, b_dm_addr = '0;
  logic [31:0] b_dm_wdata = '0;
  logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;
  logic [9:0]  b_mem_addr;

  logic [31:0] mem_a [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  // RAM model for instance A; preload port shares the write process.
  always @(posedge clk) begin
    if (pre_we)
      mem_a[pre_addr] <= pre_data;
    else if (a_mem_en && a_mem_we)
      mem_a[a_mem_addr] <= a_mem_wdata;
  end
  assign a_mem_rdata = mem_a[a_mem_addr];
  assign b_mem_rdata = 32'h0BAD0000 | {22'h0, b_mem_addr};

  mips_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(1), .STARVE_LIM(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mips_mem_arbiter #(.AW(10), .DW(32), .MEM_LAT(3), .STARVE_LIM(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic [9:0] ia, input logic dr,
                               input logic dw, input logic [9:0] da, input logic [31:0] dd);
    a_if_req   = ir;
    a_if_addr  = ia;
    a_dm_req   = dr;
    a_dm_we    = dw;
    a_dm_addr  = da;
    a_dm_wdata = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] addr, input logic [31:0] data);
    pre_we   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    tick();
    pre_we = 1'b0;
  endtask

  int n_gnt;
  int order [0:5];
  int exp_order [0:5];
  int en_cnt, busy_cnt, rv_at;

  initial begin
    #1;
    preload(10'd5, 32'h2800000A);
    preload(10'd3, 32'h11112222);
    tick();

    // Reset values
    checkOutput("rst_if_gnt",    a_if_gnt,    0);
    checkOutput("rst_dm_rvalid", a_dm_rvalid, 0);
    checkOutput("rst_mem_en",    a_mem_en,    0);
    checkOutput("rst_mem_addr",  a_mem_addr,  0);
    checkOutput("rst_if_rdata",  a_if_rdata,  0);
    checkOutput("rst_busy",      a_busy,      0);
    rst = 1'b0;
    tick();

    // IF read alone, MEM_LAT=1
    applyStimulus(1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'd0);
    tick();
    checkOutput("if_gnt_t1",   a_if_gnt, 1);
    checkOutput("mem_en_t1",   a_mem_en, 1);
    checkOutput("mem_addr_t1", a_mem_addr, 10'd5);
    applyStimulus(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    tick();
    checkOutput("if_rvalid_t2", a_if_rvalid, 1);
    checkOutput("if_rdata_t2",  a_if_rdata,  32'h2800000A);
    checkOutput("mem_en_t2",    a_mem_en,    0);
    tick();
    checkOutput("if_rvalid_t3", a_if_rvalid, 0);
    checkOutput("busy_t3",      a_busy,      0);

    // Reset asserted mid-ACCESS
    applyStimulus(1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'd0);
    tick();
    checkOutput("pre_abort_mem_en", a_mem_en, 1);
    applyStimulus(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_mem_en", a_mem_en, 0);
    checkOutput("abort_if_gnt", a_if_gnt, 0);
    checkOutput("abort_busy",   a_busy,   0);
    checkOutput("abort_rdata",  a_if_rdata, 0);
    tick();
    checkOutput("abort_rvalid", a_if_rvalid, 0);
    rst = 1'b0;
    tick();
    checkOutput("post_abort_busy",   a_busy,      0);
    checkOutput("post_abort_rvalid", a_if_rvalid, 0);

    // Simultaneous IF read and DM write: DM first
    applyStimulus(1'b1, 10'd3, 1'b1, 1'b1, 10'h100, 32'hDEADBEEF);
    tick();
    checkOutput("conf_dm_gnt",    a_dm_gnt,    1);
    checkOutput("conf_if_gnt",    a_if_gnt,    0);
    checkOutput("conf_mem_we",    a_mem_we,    1);
    checkOutput("conf_mem_addr",  a_mem_addr,  10'h100);
    checkOutput("conf_mem_wdata", a_mem_wdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 10'd3, 1'b0, 1'b0, 10'd0, 32'd0);
    tick();
    checkOutput("wr_ack",        a_dm_rvalid, 1);
    checkOutput("wr_no_if_rv",   a_if_rvalid, 0);
    checkOutput("wr_rdata_hold", a_dm_rdata,  0);
    tick();
    checkOutput("conf_idle_busy", a_busy, 0);
    tick();
    checkOutput("conf_if_gnt2",   a_if_gnt,   1);
    checkOutput("conf_if_addr2",  a_mem_addr, 10'd3);
    checkOutput("conf_if_we2",    a_mem_we,   0);
    applyStimulus(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    tick();
    checkOutput("conf_if_rvalid", a_if_rvalid, 1);
    checkOutput("conf_if_rdata",  a_if_rdata,  32'h11112222);
    tick();
    applyStimulus(1'b0, 10'd0, 1'b1, 1'b0, 10'h100, 32'd0);
    tick();
    checkOutput("rd_dm_gnt", a_dm_gnt, 1);
    applyStimulus(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    tick();
    checkOutput("rd_dm_rvalid", a_dm_rvalid, 1);
    checkOutput("rd_dm_rdata",  a_dm_rdata,  32'hDEADBEEF);
    checkOutput("rd_if_hold",   a_if_rdata,  32'h11112222);
    tick();

    // MEM_LAT=3 DM read on instance B
    b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 10'd7;
    en_cnt = 0; busy_cnt = 0; rv_at = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) begin
        checkOutput("lat3_gnt", b_dm_gnt, 1);
        b_dm_req = 1'b0;
      end
      en_cnt   += int'(b_mem_en);
      busy_cnt += int'(b_busy);
      if (b_dm_rvalid) rv_at = i;
    end
    checkOutput("lat3_en_cycles",   en_cnt,   3);
    checkOutput("lat3_busy_cycles", busy_cnt, 4);
    checkOutput("lat3_rvalid_at",   rv_at,    4);
    checkOutput("lat3_rdata",       b_dm_rdata, 32'h0BAD0007);

    // Both requests held: grant order
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int g = 0; g < 6; g++) order[g] = 2;
`ifdef ARB_FAIR_EN
    exp_order = '{0, 0, 0, 0, 1, 0};
`else
    exp_order = '{0, 0, 0, 0, 0, 0};
`endif
    applyStimulus(1'b1, 10'd1, 1'b1, 1'b0, 10'd2, 32'd0);
    n_gnt = 0;
    for (int c = 0; c < 60 && n_gnt < 6; c++) begin
      tick();
      if (a_dm_gnt) begin
        order[n_gnt] = 0;
        n_gnt++;
      end else if (a_if_gnt) begin
        order[n_gnt] = 1;
        n_gnt++;
      end
    end
    checkOutput("held_grant_count", n_gnt, 6);
    for (int g = 0; g < 6; g++)
      checkOutput($sformatf("held_grant%0d_is_if", g), order[g], exp_order[g]);
    applyStimulus(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
